// File: rtl/store_checker_pkg.sv
// Shared types and constants for the data-memory store checker.
package store_checker_pkg;

  localparam int unsigned IDX_W  = 6;
  localparam int unsigned SEEN_W = IDX_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_DATA    = 2'd1,
    FC_ADDR    = 2'd2,
    FC_TIMEOUT = 2'd3
  } fail_code_e;

endpackage

// File: rtl/store_checker_if.sv
// Store snoop, table programming and verdict signals of the store checker.
interface store_checker_if
  import store_checker_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);

  logic              start;
  logic              MemWrite;
  logic [ADDR_W-1:0] DataAdr;
  logic [DATA_W-1:0] WriteData;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [DATA_W-1:0] cfg_exp;
  logic [DATA_W-1:0] cfg_mask;
  logic              done;
  logic              pass;
  logic              fail;
  logic [1:0]        fail_code;
  logic [IDX_W-1:0]  fail_idx;
  logic [DATA_W-1:0] fail_data;
  logic [SEEN_W-1:0] checks_seen;

  modport master (
    output start, MemWrite, DataAdr, WriteData, cfg_we, cfg_idx, cfg_exp, cfg_mask,
    input  done, pass, fail, fail_code, fail_idx, fail_data, checks_seen
  );

  modport slave (
    input  start, MemWrite, DataAdr, WriteData, cfg_we, cfg_idx, cfg_exp, cfg_mask,
    output done, pass, fail, fail_code, fail_idx, fail_data, checks_seen
  );

endinterface

// File: rtl/store_checker_table.sv
// Expected-word / compare-mask register file; contents survive reset.
module store_checker_table
  import store_checker_pkg::*;
#(
  parameter int unsigned NUM_CHECKS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [IDX_W-1:0]  wrIdx,
  input  logic [DATA_W-1:0] wrExp,
  input  logic [DATA_W-1:0] wrMask,
  input  logic [IDX_W-1:0]  rdIdx,
  output logic [DATA_W-1:0] rdExp_c,
  output logic [DATA_W-1:0] rdMask_c
);

  logic [DATA_W-1:0] expMem  [NUM_CHECKS];
  logic [DATA_W-1:0] maskMem [NUM_CHECKS];

  // Single write port, entry selected by index
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_CHECKS); i++) begin
      if (wrEn && (wrIdx == IDX_W'(i))) begin
        expMem[i]  <= wrExp;
        maskMem[i] <= wrMask;
      end
    end
  end

  // Combinational read; out-of-range index reads as zero
  always_comb begin
    rdExp_c  = '0;
    rdMask_c = '0;
    for (int i = 0; i < int'(NUM_CHECKS); i++) begin
      if (rdIdx == IDX_W'(i)) begin
        rdExp_c  = expMem[i];
        rdMask_c = maskMem[i];
      end
    end
  end

endmodule

// File: rtl/store_checker.sv
// Snoops core stores and checks them against a table of expected words.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned NUM_CHECKS = 9,
  parameter int unsigned BASE_ADDR  = 200,
  parameter int unsigned STRIDE     = 4,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned IN_ORDER   = 1
) (
  input logic            clk,
  input logic            reset,
  store_checker_if.slave bus
);

  localparam int unsigned CNT_W = 32;

  state_e              stateQ, stateD;
  logic [CNT_W-1:0]    cntQ, cntD;
  logic [NUM_CHECKS-1:0] seenQ, seenD;
  logic [SEEN_W-1:0]   checksQ, checksD;
  logic                doneQ, doneD, passQ, passD, failQ, failD;
  fail_code_e          codeQ, codeD;
  logic [IDX_W-1:0]    idxQ, idxD;
  logic [DATA_W-1:0]   dataQ, dataD;

  logic [ADDR_W-1:0]     offset, slot;
  logic                  addrOk, orderOk, dataBad, alreadySeen, tableWe;
  logic [IDX_W-1:0]      storeIdx;
  logic [NUM_CHECKS-1:0] slotBit;
  logic [DATA_W-1:0]     rdExp, rdMask;

  // Address decode into a table slot
  assign offset   = bus.DataAdr - ADDR_W'(BASE_ADDR);
  assign slot     = offset / ADDR_W'(STRIDE);
  assign addrOk   = ((offset % ADDR_W'(STRIDE)) == '0) && (slot < ADDR_W'(NUM_CHECKS));
  assign storeIdx = addrOk ? IDX_W'(slot) : IDX_W'(NUM_CHECKS);
  assign slotBit  = NUM_CHECKS'(1) << storeIdx;

  assign orderOk     = ({1'b0, storeIdx} == checksQ);
  assign alreadySeen = |(seenQ & slotBit);
  assign dataBad     = |((bus.WriteData ^ rdExp) & rdMask);
  assign tableWe     = bus.cfg_we && (stateQ == ST_IDLE)
                       && ({1'b0, bus.cfg_idx} < SEEN_W'(NUM_CHECKS));

  store_checker_table #(
    .NUM_CHECKS(NUM_CHECKS),
    .DATA_W    (DATA_W)
  ) uTable (
    .clk     (clk),
    .wrEn    (tableWe),
    .wrIdx   (bus.cfg_idx),
    .wrExp   (bus.cfg_exp),
    .wrMask  (bus.cfg_mask),
    .rdIdx   (storeIdx),
    .rdExp_c (rdExp),
    .rdMask_c(rdMask)
  );

  // State, counters and verdict registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ  <= ST_IDLE;
      cntQ    <= '0;
      seenQ   <= '0;
      checksQ <= '0;
      doneQ   <= 1'b0;
      passQ   <= 1'b0;
      failQ   <= 1'b0;
      codeQ   <= FC_NONE;
      idxQ    <= '0;
      dataQ   <= '0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      seenQ   <= seenD;
      checksQ <= checksD;
      doneQ   <= doneD;
      passQ   <= passD;
      failQ   <= failD;
      codeQ   <= codeD;
      idxQ    <= idxD;
      dataQ   <= dataD;
    end
  end

  // Next state: store evaluation first, timeout only if no verdict was reached
  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    seenD   = seenQ;
    checksD = checksQ;
    doneD   = doneQ;
    passD   = passQ;
    failD   = failQ;
    codeD   = codeQ;
    idxD    = idxQ;
    dataD   = dataQ;
    case (stateQ)
      ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (bus.start) begin
          stateD  = ST_RUN;
          cntD    = '0;
          seenD   = '0;
          checksD = '0;
          doneD   = 1'b0;
          passD   = 1'b0;
          failD   = 1'b0;
          codeD   = FC_NONE;
          idxD    = '0;
          dataD   = '0;
        end
      end
      ST_RUN: begin
        cntD = cntQ + CNT_W'(1);
        if (bus.MemWrite) begin
          if (!addrOk || ((IN_ORDER != 0) && !orderOk)) begin
            stateD = ST_FAIL;
            doneD  = 1'b1;
            failD  = 1'b1;
            codeD  = FC_ADDR;
            idxD   = storeIdx;
            dataD  = bus.WriteData;
          end else if (dataBad) begin
            stateD = ST_FAIL;
            doneD  = 1'b1;
            failD  = 1'b1;
            codeD  = FC_DATA;
            idxD   = storeIdx;
            dataD  = bus.WriteData;
          end else if (!alreadySeen) begin
            seenD   = seenQ | slotBit;
            checksD = checksQ + SEEN_W'(1);
            if (checksD == SEEN_W'(NUM_CHECKS)) begin
              stateD = ST_PASS;
              doneD  = 1'b1;
              passD  = 1'b1;
            end
          end
        end
        if ((TIMEOUT != 0) && (stateD == ST_RUN) && (cntD == CNT_W'(TIMEOUT))) begin
          stateD = ST_TIMEOUT;
          doneD  = 1'b1;
          failD  = 1'b1;
          codeD  = FC_TIMEOUT;
          idxD   = IDX_W'(checksD);
          dataD  = '0;
        end
      end
      default: stateD = ST_IDLE;
    endcase
  end

  assign bus.done        = doneQ;
  assign bus.pass        = passQ;
  assign bus.fail        = failQ;
  assign bus.fail_code   = codeQ;
  assign bus.fail_idx    = idxQ;
  assign bus.fail_data   = dataQ;
  assign bus.checks_seen = checksQ;

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: in-order/any-order/timeout instances share one stimulus stream.
module tb_store_checker;
  import store_checker_pkg::*;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        fail;
    logic [1:0]  code;
    logic [5:0]  idx;
    logic [31:0] data;
    logic [6:0]  seen;
  } verdict_t;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start, memWrite, cfgWe;
  logic [31:0] dataAdr, writeData, cfgExp, cfgMask;
  logic [5:0]  cfgIdx;

  int total = 0;
  int bad   = 0;

  verdict_t expA[$];
  verdict_t expB[$];
  verdict_t o, e;

  logic [31:0] golden [9] = '{32'h4585e600, 32'h45c8c700, 32'h9C66BC00, 32'h40000000,
                              32'h0BCC6700, 32'h40000000, 32'h00004040, 32'h00003A80,
                              32'h00000000};

  always #5 clk = ~clk;

  store_checker_if #(.DATA_W(32), .ADDR_W(32)) busA ();
  store_checker_if #(.DATA_W(32), .ADDR_W(32)) busB ();

  assign busA.start = start;     assign busB.start = start;
  assign busA.MemWrite = memWrite; assign busB.MemWrite = memWrite;
  assign busA.DataAdr = dataAdr; assign busB.DataAdr = dataAdr;
  assign busA.WriteData = writeData; assign busB.WriteData = writeData;
  assign busA.cfg_we = cfgWe;    assign busB.cfg_we = cfgWe;
  assign busA.cfg_idx = cfgIdx;  assign busB.cfg_idx = cfgIdx;
  assign busA.cfg_exp = cfgExp;  assign busB.cfg_exp = cfgExp;
  assign busA.cfg_mask = cfgMask; assign busB.cfg_mask = cfgMask;

  // A: in-order, long timeout.  B: any-order, timeout 50.
  store_checker #(.DATA_W(32), .ADDR_W(32), .NUM_CHECKS(9), .BASE_ADDR(200), .STRIDE(4),
                  .TIMEOUT(4096), .IN_ORDER(1)) dutA (.clk(clk), .reset(resetN), .bus(busA));
  store_checker #(.DATA_W(32), .ADDR_W(32), .NUM_CHECKS(9), .BASE_ADDR(200), .STRIDE(4),
                  .TIMEOUT(50), .IN_ORDER(0)) dutB (.clk(clk), .reset(resetN), .bus(busB));

  function automatic verdict_t obsA();
    return {busA.done, busA.pass, busA.fail, busA.fail_code, busA.fail_idx,
            busA.fail_data, busA.checks_seen};
  endfunction

  function automatic verdict_t obsB();
    return {busB.done, busB.pass, busB.fail, busB.fail_code, busB.fail_idx,
            busB.fail_data, busB.checks_seen};
  endfunction

  function automatic verdict_t mkV(input logic d, input logic p, input logic f,
                                   input logic [1:0] c, input logic [5:0] i,
                                   input logic [31:0] w, input logic [6:0] s);
    return {d, p, f, c, i, w, s};
  endfunction

  function automatic string fmtV(input verdict_t v);
    return $sformatf("done=%0b pass=%0b fail=%0b code=%0d idx=%0d data=%h seen=%0d",
                     v.done, v.pass, v.fail, v.code, v.idx, v.data, v.seen);
  endfunction

  task automatic storeOp(input logic [31:0] addr, input logic [31:0] data);
    memWrite = 1'b1; dataAdr = addr; writeData = data;
    @(negedge clk);
    memWrite = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic progEntry(input logic [5:0] idx, input logic [31:0] ex, input logic [31:0] mk);
    cfgWe = 1'b1; cfgIdx = idx; cfgExp = ex; cfgMask = mk;
    @(negedge clk);
    cfgWe = 1'b0;
  endtask

  task automatic doReset();
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic inOrderStores(input int first, input int last);
    for (int i = first; i <= last; i++) storeOp(32'(200 + 4 * i), golden[i]);
  endtask

  task automatic test_reset();
    start = 0; memWrite = 0; dataAdr = 0; writeData = 0;
    cfgWe = 0; cfgIdx = 0; cfgExp = 0; cfgMask = 0;
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    o = obsA(); total++;
    if (o !== '0) begin bad++; $display("FAIL reset_A: got %s want all zero", fmtV(o)); end
    o = obsB(); total++;
    if (o !== '0) begin bad++; $display("FAIL reset_B: got %s want all zero", fmtV(o)); end
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_program_and_idle();
    for (int i = 0; i < 9; i++) progEntry(6'(i), golden[i], 32'hFFFFFFFF);
    storeOp(32'd240, 32'h1);
    storeOp(32'd200, 32'h5);
    o = obsA(); total++;
    if (o !== '0) begin bad++; $display("FAIL idle_store_A: got %s want all zero", fmtV(o)); end
    o = obsB(); total++;
    if (o !== '0) begin bad++; $display("FAIL idle_store_B: got %s want all zero", fmtV(o)); end
  endtask

  task automatic test_in_order_pass();
    pulseStart();
    inOrderStores(0, 7);
    o = obsA(); e = mkV(0, 0, 0, FC_NONE, 0, 0, 8); total++;
    if (o !== e) begin bad++; $display("FAIL pre_last_A: got %s want %s", fmtV(o), fmtV(e)); end
    expA.push_back(mkV(1, 1, 0, FC_NONE, 0, 0, 9));
    expB.push_back(mkV(1, 1, 0, FC_NONE, 0, 0, 9));
    storeOp(32'd232, golden[8]);
    o = obsA(); e = expA.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL pass_A: got %s want %s", fmtV(o), fmtV(e)); end
    o = obsB(); e = expB.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL pass_B: got %s want %s", fmtV(o), fmtV(e)); end
  endtask

  task automatic test_data_mismatch();
    pulseStart();
    o = obsA(); total++;
    if (o !== '0) begin bad++; $display("FAIL restart_clear_A: got %s want all zero", fmtV(o)); end
    storeOp(32'd200, golden[0]);
    expA.push_back(mkV(1, 0, 1, FC_DATA, 1, 32'h45c8c701, 1));
    expB.push_back(mkV(1, 0, 1, FC_DATA, 1, 32'h45c8c701, 1));
    storeOp(32'd204, 32'h45c8c701);
    o = obsA(); e = expA.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL data_A: got %s want %s", fmtV(o), fmtV(e)); end
    o = obsB(); e = expB.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL data_B: got %s want %s", fmtV(o), fmtV(e)); end
    storeOp(32'd208, golden[2]);
    storeOp(32'd240, 32'h0);
    o = obsA(); e = mkV(1, 0, 1, FC_DATA, 1, 32'h45c8c701, 1); total++;
    if (o !== e) begin bad++; $display("FAIL data_hold_A: got %s want %s", fmtV(o), fmtV(e)); end
  endtask

  task automatic test_bad_addr();
    pulseStart();
    expA.push_back(mkV(1, 0, 1, FC_ADDR, 9, 32'hCAFEF00D, 0));
    expB.push_back(mkV(1, 0, 1, FC_ADDR, 9, 32'hCAFEF00D, 0));
    storeOp(32'd240, 32'hCAFEF00D);
    o = obsA(); e = expA.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL addr240_A: got %s want %s", fmtV(o), fmtV(e)); end
    o = obsB(); e = expB.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL addr240_B: got %s want %s", fmtV(o), fmtV(e)); end
    pulseStart();
    storeOp(32'd200, golden[0]);
    expA.push_back(mkV(1, 0, 1, FC_ADDR, 9, 32'h00000011, 1));
    expB.push_back(mkV(1, 0, 1, FC_ADDR, 9, 32'h00000011, 1));
    storeOp(32'd202, 32'h00000011);
    o = obsA(); e = expA.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL addr202_A: got %s want %s", fmtV(o), fmtV(e)); end
    o = obsB(); e = expB.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL addr202_B: got %s want %s", fmtV(o), fmtV(e)); end
  endtask

  task automatic test_any_order();
    pulseStart();
    expA.push_back(mkV(1, 0, 1, FC_ADDR, 2, golden[2], 0));
    storeOp(32'd208, golden[2]);
    o = obsA(); e = expA.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL order_A: got %s want %s", fmtV(o), fmtV(e)); end
    storeOp(32'd200, golden[0]);
    storeOp(32'd200, golden[0]);
    o = obsB(); e = mkV(0, 0, 0, FC_NONE, 0, 0, 2); total++;
    if (o !== e) begin bad++; $display("FAIL repeat_B: got %s want %s", fmtV(o), fmtV(e)); end
    storeOp(32'd204, golden[1]);
    inOrderStores(3, 7);
    expB.push_back(mkV(1, 1, 0, FC_NONE, 0, 0, 9));
    storeOp(32'd232, golden[8]);
    o = obsB(); e = expB.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL anyorder_B: got %s want %s", fmtV(o), fmtV(e)); end
    o = obsA(); e = mkV(1, 0, 1, FC_ADDR, 2, golden[2], 0); total++;
    if (o !== e) begin bad++; $display("FAIL order_hold_A: got %s want %s", fmtV(o), fmtV(e)); end
    // repeat with a wrong value: order error for A, data error for B
    pulseStart();
    expA.push_back(mkV(1, 0, 1, FC_ADDR, 1, golden[1], 0));
    storeOp(32'd204, golden[1]);
    expB.push_back(mkV(1, 0, 1, FC_DATA, 1, golden[1] ^ 32'h1, 1));
    storeOp(32'd204, golden[1] ^ 32'h1);
    o = obsA(); e = expA.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL first204_A: got %s want %s", fmtV(o), fmtV(e)); end
    o = obsB(); e = expB.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL rebad204_B: got %s want %s", fmtV(o), fmtV(e)); end
  endtask

  task automatic test_timeout_and_reset();
    pulseStart();
    inOrderStores(0, 2);
    repeat (46) @(negedge clk);
    o = obsB(); e = mkV(0, 0, 0, FC_NONE, 0, 0, 3); total++;
    if (o !== e) begin bad++; $display("FAIL pre_timeout_B: got %s want %s", fmtV(o), fmtV(e)); end
    expB.push_back(mkV(1, 0, 1, FC_TIMEOUT, 3, 0, 3));
    @(negedge clk);
    o = obsB(); e = expB.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL timeout_B: got %s want %s", fmtV(o), fmtV(e)); end
    o = obsA(); e = mkV(0, 0, 0, FC_NONE, 0, 0, 3); total++;
    if (o !== e) begin bad++; $display("FAIL no_timeout_A: got %s want %s", fmtV(o), fmtV(e)); end
    #2 resetN = 1'b0;
    #1;
    o = obsA(); total++;
    if (o !== '0) begin bad++; $display("FAIL async_reset_A: got %s want all zero", fmtV(o)); end
    o = obsB(); total++;
    if (o !== '0) begin bad++; $display("FAIL async_reset_B: got %s want all zero", fmtV(o)); end
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass_on_timeout_cycle();
    pulseStart();
    repeat (41) @(negedge clk);
    inOrderStores(0, 7);
    expB.push_back(mkV(1, 1, 0, FC_NONE, 0, 0, 9));
    storeOp(32'd232, golden[8]);
    o = obsB(); e = expB.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL edge_pass_B: got %s want %s", fmtV(o), fmtV(e)); end
  endtask

  task automatic test_mask();
    doReset();
    progEntry(6'd8, 32'h0, 32'h0000FFFF);
    pulseStart();
    inOrderStores(0, 7);
    expA.push_back(mkV(1, 1, 0, FC_NONE, 0, 0, 9));
    expB.push_back(mkV(1, 1, 0, FC_NONE, 0, 0, 9));
    storeOp(32'd232, 32'h12340000);
    o = obsA(); e = expA.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL mask_hi_A: got %s want %s", fmtV(o), fmtV(e)); end
    o = obsB(); e = expB.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL mask_hi_B: got %s want %s", fmtV(o), fmtV(e)); end
    doReset();
    pulseStart();
    inOrderStores(0, 7);
    expA.push_back(mkV(1, 0, 1, FC_DATA, 8, 32'h12340001, 8));
    expB.push_back(mkV(1, 0, 1, FC_DATA, 8, 32'h12340001, 8));
    storeOp(32'd232, 32'h12340001);
    o = obsA(); e = expA.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL mask_lo_A: got %s want %s", fmtV(o), fmtV(e)); end
    o = obsB(); e = expB.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL mask_lo_B: got %s want %s", fmtV(o), fmtV(e)); end
    doReset();
    progEntry(6'd8, 32'h0, 32'h0);
    pulseStart();
    progEntry(6'd0, 32'h12345678, 32'hFFFFFFFF);
    inOrderStores(0, 7);
    expA.push_back(mkV(1, 1, 0, FC_NONE, 0, 0, 9));
    expB.push_back(mkV(1, 1, 0, FC_NONE, 0, 0, 9));
    storeOp(32'd232, 32'hFFFFFFFF);
    o = obsA(); e = expA.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL mask0_A: got %s want %s", fmtV(o), fmtV(e)); end
    o = obsB(); e = expB.pop_front(); total++;
    if (o !== e) begin bad++; $display("FAIL mask0_B: got %s want %s", fmtV(o), fmtV(e)); end
  endtask

  initial begin
    test_reset();
    test_program_and_idle();
    test_in_order_pass();
    test_data_mismatch();
    test_bad_addr();
    test_any_order();
    test_timeout_and_reset();
    test_pass_on_timeout_cycle();
    test_mask();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
